// File: rtl/jal_jr_control_sequencer.sv
// ---------------------------------------------------------------------------
// jal_jr_control_sequencer
//   Hardwired control sequencer for the bus datapath. Walks the fetch
//   sequence (T0..T2) and then the per-class execute steps (T3..T6) for
//   ldi, jal, jr, br, nop and halt, and drives the one-hot datapath strobes.
//
// Ports
//   clock, clear        rising-edge clock, synchronous active-high reset
//   run                 level; start/continue executing (sampled in IDLE and
//                       at instruction end states only)
//   IR                  datapath IR; only IR[31:27] (opcode) is used
//   ConFFQ              datapath condition FF, consumed in br's T6
//   PCout..CONin        datapath control strobes (Moore, decoded from state)
//   halted              high while parked in HALT
//   illegal             one-cycle pulse in T3 for an unknown opcode
//   instr_count         retired-instruction counter, wraps
//   state               encoded current state (debug)
// ---------------------------------------------------------------------------
module jal_jr_control_sequencer #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 16,
  parameter logic [4:0]  OP_LDI   = 5'h08,
  parameter logic [4:0]  OP_BR    = 5'h12,
  parameter logic [4:0]  OP_JR    = 5'h14,
  parameter logic [4:0]  OP_JAL   = 5'h15,
  parameter logic [4:0]  OP_NOP   = 5'h1A,
  parameter logic [4:0]  OP_HALT  = 5'h1B
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      IR,
  input  logic             ConFFQ,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDMuxread,
  output logic             RAMread,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Zlowin,
  output logic             Zlowout,
  output logic             Yin,
  output logic             ADD,
  output logic             CSEout,
  output logic             Gra,
  output logic             Grb,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             CONin,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  localparam int unsigned OP_W   = 5;
  localparam int unsigned WAIT_W = 3;
  // Wait counter value on the final T1 cycle (MEM_WAIT is limited to 0..7).
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CL_LDI,
    CL_JAL,
    CL_JR,
    CL_BR,
    CL_NOP,
    CL_HALT,
    CL_ILL
  } op_class_e;

  // Map a raw opcode onto an instruction class.
  function automatic op_class_e classify(input logic [OP_W-1:0] op);
    if (op == OP_LDI)  return CL_LDI;
    if (op == OP_JAL)  return CL_JAL;
    if (op == OP_JR)   return CL_JR;
    if (op == OP_BR)   return CL_BR;
    if (op == OP_NOP)  return CL_NOP;
    if (op == OP_HALT) return CL_HALT;
    return CL_ILL;
  endfunction

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              halted_q, halted_d;

  logic [OP_W-1:0]   ir_op;
  op_class_e         ir_cls;
  op_class_e         op_cls;
  logic              retire;
  logic              unused_ir;

  assign ir_op     = IR[31:27];
  assign unused_ir = ^IR[26:0];
  // T3 decodes the live IR; T4..T6 decode the opcode captured on T3 exit.
  assign ir_cls    = classify(ir_op);
  assign op_cls    = classify(op_q);

  // Next-state, counters and Moore strobe decode.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    op_d      = op_q;
    count_d   = count_q;
    retire    = 1'b0;
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    MDMuxread = 1'b0;
    RAMread   = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Zlowin    = 1'b0;
    Zlowout   = 1'b0;
    Yin       = 1'b0;
    ADD       = 1'b0;
    CSEout    = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    CONin     = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_T0;
      end

      // MAR <- PC, Z <- PC+1
      ST_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zlowin  = 1'b1;
        wait_d  = '0;
        state_d = ST_T1;
      end

      // Memory read held for 1+MEM_WAIT cycles; PC update on the first,
      // MDR capture on the last.
      ST_T1: begin
        MDMuxread = 1'b1;
        RAMread   = 1'b1;
        if (wait_q == '0) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
        end
        if (wait_q == WAIT_LAST) begin
          MDRin   = 1'b1;
          wait_d  = '0;
          state_d = ST_T2;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end

      ST_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = ST_T3;
      end

      ST_T3: begin
        op_d = ir_op;
        case (ir_cls)
          CL_LDI: begin
            Grb     = 1'b1;
            BAout   = 1'b1;
            Yin     = 1'b1;
            state_d = ST_T4;
          end
          // Link register (Rb) receives the already-incremented PC.
          CL_JAL: begin
            PCout   = 1'b1;
            Grb     = 1'b1;
            Rin     = 1'b1;
            state_d = ST_T4;
          end
          CL_JR: begin
            Gra    = 1'b1;
            Rout   = 1'b1;
            PCin   = 1'b1;
            retire = 1'b1;
          end
          CL_BR: begin
            Gra     = 1'b1;
            Rout    = 1'b1;
            CONin   = 1'b1;
            state_d = ST_T4;
          end
          CL_NOP: begin
            retire = 1'b1;
          end
          // halt retires here and parks; run is not consulted.
          CL_HALT: begin
            count_d = count_q + CNT_W'(1);
            state_d = ST_HALT;
          end
          default: begin
            illegal = 1'b1;
            retire  = 1'b1;
          end
        endcase
      end

      ST_T4: begin
        case (op_cls)
          CL_LDI: begin
            CSEout  = 1'b1;
            ADD     = 1'b1;
            Zlowin  = 1'b1;
            state_d = ST_T5;
          end
          CL_JAL: begin
            Gra    = 1'b1;
            Rout   = 1'b1;
            PCin   = 1'b1;
            retire = 1'b1;
          end
          CL_BR: begin
            PCout   = 1'b1;
            Yin     = 1'b1;
            state_d = ST_T5;
          end
          default: retire = 1'b1;
        endcase
      end

      ST_T5: begin
        case (op_cls)
          CL_LDI: begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
            retire  = 1'b1;
          end
          CL_BR: begin
            CSEout  = 1'b1;
            ADD     = 1'b1;
            Zlowin  = 1'b1;
            state_d = ST_T6;
          end
          default: retire = 1'b1;
        endcase
      end

      // Branch target is in Z; take it only when the CON FF is set.
      ST_T6: begin
        Zlowout = 1'b1;
        PCin    = ConFFQ;
        retire  = 1'b1;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Common end-of-instruction handling: count and chain without a bubble.
    if (retire) begin
      count_d = count_q + CNT_W'(1);
      state_d = run ? ST_T0 : ST_IDLE;
    end

    halted_d = (state_d == ST_HALT);
  end

  // State and counter registers; clear wins over everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      op_q     <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      op_q     <= op_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  assign halted      = halted_q;
  assign instr_count = count_q;
  assign state       = state_q;

  // With wait states, the PC update and the MDR capture never overlap.
  a_pcin_mdrin: assert property (@(posedge clock) disable iff (clear)
    (MEM_WAIT == 0) || !(PCin && MDRin));

  // illegal is only ever raised from T3.
  a_illegal_t3: assert property (@(posedge clock) disable iff (clear)
    illegal |-> (state_q == ST_T3));

  // HALT is left only through clear.
  a_halt_sticky: assert property (@(posedge clock) disable iff (clear)
    (state_q == ST_HALT) |=> (state_q == ST_HALT));

endmodule

// File: tb/tb_jal_jr_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jal_jr_control_sequencer
//   Main DUT (MEM_WAIT=0) runs a small program against a bench datapath;
//   a cycle-indexed instruction model predicts every strobe each cycle.
//   A second DUT (MEM_WAIT=2) gets directed wait-state checks.
// ---------------------------------------------------------------------------
module tb_jal_jr_control_sequencer;

  localparam int MW = 0;
  localparam int CW = 16;
  localparam int F  = 3 + MW;   // cycle index of T3 within an instruction

  localparam logic [4:0] OP_LDI  = 5'h08;
  localparam logic [4:0] OP_BR   = 5'h12;
  localparam logic [4:0] OP_JR   = 5'h14;
  localparam logic [4:0] OP_JAL  = 5'h15;
  localparam logic [4:0] OP_NOP  = 5'h1A;
  localparam logic [4:0] OP_HALT = 5'h1B;

  // Strobe positions within the packed strobe vectors.
  localparam int B_PCOUT = 19, B_PCIN = 18, B_INCPC = 17, B_MARIN = 16;
  localparam int B_MDMUX = 15, B_RAMRD = 14, B_MDRIN = 13, B_MDROUT = 12;
  localparam int B_IRIN = 11, B_ZIN = 10, B_ZOUT = 9, B_YIN = 8, B_ADD = 7;
  localparam int B_CSE = 6, B_GRA = 5, B_GRB = 4, B_RIN = 3, B_ROUT = 2;
  localparam int B_BAOUT = 1, B_CONIN = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           clear, run;
  logic [19:0]    v1;
  logic           halted, illegal;
  logic [CW-1:0]  instr_count;
  logic [3:0]     state;

  logic           clear2, run2, con2;
  logic [31:0]    ir2;
  logic [19:0]    v2;
  logic           halted2, illegal2;
  logic [CW-1:0]  count2;
  logic [3:0]     state2;

  // Bench datapath
  logic [31:0] mem [256];
  logic [31:0] regs [16];
  logic [31:0] dp_pc, dp_mdr, dp_ir, dp_y, dp_z, bus, pc_init;
  logic [7:0]  dp_mar;
  logic        dp_con;
  logic [3:0]  sel;
  logic [31:0] pcq[$];

  int n_tests = 0;
  int n_fail  = 0;

  jal_jr_control_sequencer #(.MEM_WAIT(MW), .CNT_W(CW)) u_dut (
    .clock(clock), .clear(clear), .run(run), .IR(dp_ir), .ConFFQ(dp_con),
    .PCout(v1[B_PCOUT]), .PCin(v1[B_PCIN]), .IncPC(v1[B_INCPC]), .MARin(v1[B_MARIN]),
    .MDMuxread(v1[B_MDMUX]), .RAMread(v1[B_RAMRD]), .MDRin(v1[B_MDRIN]),
    .MDRout(v1[B_MDROUT]), .IRin(v1[B_IRIN]), .Zlowin(v1[B_ZIN]), .Zlowout(v1[B_ZOUT]),
    .Yin(v1[B_YIN]), .ADD(v1[B_ADD]), .CSEout(v1[B_CSE]), .Gra(v1[B_GRA]),
    .Grb(v1[B_GRB]), .Rin(v1[B_RIN]), .Rout(v1[B_ROUT]), .BAout(v1[B_BAOUT]),
    .CONin(v1[B_CONIN]), .halted(halted), .illegal(illegal),
    .instr_count(instr_count), .state(state)
  );

  jal_jr_control_sequencer #(.MEM_WAIT(2), .CNT_W(CW)) u_dut_w2 (
    .clock(clock), .clear(clear2), .run(run2), .IR(ir2), .ConFFQ(con2),
    .PCout(v2[B_PCOUT]), .PCin(v2[B_PCIN]), .IncPC(v2[B_INCPC]), .MARin(v2[B_MARIN]),
    .MDMuxread(v2[B_MDMUX]), .RAMread(v2[B_RAMRD]), .MDRin(v2[B_MDRIN]),
    .MDRout(v2[B_MDROUT]), .IRin(v2[B_IRIN]), .Zlowin(v2[B_ZIN]), .Zlowout(v2[B_ZOUT]),
    .Yin(v2[B_YIN]), .ADD(v2[B_ADD]), .CSEout(v2[B_CSE]), .Gra(v2[B_GRA]),
    .Grb(v2[B_GRB]), .Rin(v2[B_RIN]), .Rout(v2[B_ROUT]), .BAout(v2[B_BAOUT]),
    .CONin(v2[B_CONIN]), .halted(halted2), .illegal(illegal2),
    .instr_count(count2), .state(state2)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Datapath bus sources
  always_comb begin
    sel = v1[B_GRA] ? dp_ir[26:23] : dp_ir[22:19];
    bus = '0;
    if (v1[B_PCOUT])       bus = dp_pc;
    else if (v1[B_MDROUT]) bus = dp_mdr;
    else if (v1[B_ZOUT])   bus = dp_z;
    else if (v1[B_ROUT])   bus = regs[sel];
    else if (v1[B_BAOUT])  bus = (sel == 4'd0) ? 32'd0 : regs[sel];
    else if (v1[B_CSE])    bus = {{13{dp_ir[18]}}, dp_ir[18:0]};
  end

  // Datapath registers; CON is set when the branch register is nonzero.
  always @(posedge clock) begin
    if (clear) begin
      dp_pc <= pc_init; dp_mar <= '0; dp_mdr <= '0; dp_ir <= '0;
      dp_y <= '0; dp_z <= '0; dp_con <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      if (v1[B_PCIN])  begin dp_pc <= bus; pcq.push_back(bus); end
      if (v1[B_MARIN]) dp_mar <= bus[7:0];
      if (v1[B_MDRIN]) dp_mdr <= v1[B_MDMUX] ? mem[dp_mar] : bus;
      if (v1[B_IRIN])  dp_ir <= bus;
      if (v1[B_YIN])   dp_y <= bus;
      if (v1[B_RIN])   regs[sel] <= bus;
      if (v1[B_CONIN]) dp_con <= (bus != 32'd0);
      if (v1[B_ZIN])   dp_z <= v1[B_INCPC] ? bus + 32'd1 : (v1[B_ADD] ? dp_y + bus : bus);
    end
  end

  // Instruction length in cycles, per class.
  function automatic int ilen(input logic [4:0] op);
    case (op)
      OP_LDI:  return 6 + MW;
      OP_JAL:  return 5 + MW;
      OP_BR:   return 7 + MW;
      default: return 4 + MW;
    endcase
  endfunction

  function automatic bit known(input logic [4:0] op);
    return op == OP_LDI || op == OP_JAL || op == OP_JR || op == OP_BR ||
           op == OP_NOP || op == OP_HALT;
  endfunction

  // Expected strobes on cycle s of an instruction with opcode op.
  function automatic logic [19:0] exp_vec(input int s, input logic [4:0] op, input logic cfq);
    logic [19:0] v;
    int k;
    v = '0;
    k = s - F;
    if (s == 0) begin
      v[B_PCOUT] = 1; v[B_MARIN] = 1; v[B_INCPC] = 1; v[B_ZIN] = 1;
    end else if (s <= 1 + MW) begin
      v[B_MDMUX] = 1; v[B_RAMRD] = 1;
      if (s == 1)      begin v[B_ZOUT] = 1; v[B_PCIN] = 1; end
      if (s == 1 + MW) v[B_MDRIN] = 1;
    end else if (s == 2 + MW) begin
      v[B_MDROUT] = 1; v[B_IRIN] = 1;
    end else begin
      case (op)
        OP_LDI: begin
          if (k == 0) begin v[B_GRB] = 1; v[B_BAOUT] = 1; v[B_YIN] = 1; end
          if (k == 1) begin v[B_CSE] = 1; v[B_ADD] = 1; v[B_ZIN] = 1; end
          if (k == 2) begin v[B_ZOUT] = 1; v[B_GRA] = 1; v[B_RIN] = 1; end
        end
        OP_JAL: begin
          if (k == 0) begin v[B_PCOUT] = 1; v[B_GRB] = 1; v[B_RIN] = 1; end
          if (k == 1) begin v[B_GRA] = 1; v[B_ROUT] = 1; v[B_PCIN] = 1; end
        end
        OP_JR: begin
          if (k == 0) begin v[B_GRA] = 1; v[B_ROUT] = 1; v[B_PCIN] = 1; end
        end
        OP_BR: begin
          if (k == 0) begin v[B_GRA] = 1; v[B_ROUT] = 1; v[B_CONIN] = 1; end
          if (k == 1) begin v[B_PCOUT] = 1; v[B_YIN] = 1; end
          if (k == 2) begin v[B_CSE] = 1; v[B_ADD] = 1; v[B_ZIN] = 1; end
          if (k == 3) begin v[B_ZOUT] = 1; v[B_PCIN] = cfq; end
        end
        default: ;
      endcase
    end
    return v;
  endfunction

  // Instruction-level model: mode, cycle index within instruction, count.
  int            m_mode = M_IDLE;
  int            m_step = 0;
  logic [CW-1:0] m_count = '0;
  bit            m_valid = 1'b0;

  always @(posedge clock) begin
    if (clear) begin
      m_valid <= 1'b1; m_mode <= M_IDLE; m_step <= 0; m_count <= '0;
    end else if (m_valid) begin
      case (m_mode)
        M_IDLE: if (run) begin m_mode <= M_RUN; m_step <= 0; end
        M_RUN: begin
          if (m_step >= F && m_step == ilen(dp_ir[31:27]) - 1) begin
            m_count <= m_count + 1'b1;
            if (dp_ir[31:27] == OP_HALT) m_mode <= M_HALT;
            else if (run)                m_step <= 0;
            else                         m_mode <= M_IDLE;
          end else begin
            m_step <= m_step + 1;
          end
        end
        default: ;
      endcase
    end
  end

  int ill_seen = 0;
  int pcin_seen = 0;
  bit watch_pcin = 1'b0;

  // Per-cycle compare of the main DUT against the model.
  always @(negedge clock) begin
    logic [19:0] ev;
    logic        eill;
    if (m_valid) begin
      ev   = (m_mode == M_RUN) ? exp_vec(m_step, dp_ir[31:27], dp_con) : 20'd0;
      eill = (m_mode == M_RUN) && (m_step == F) && !known(dp_ir[31:27]);
      check("cycle", {26'd0, v1, illegal, halted, instr_count},
            {26'd0, ev, eill, (m_mode == M_HALT), m_count});
    end
    if (illegal) ill_seen++;
    if (watch_pcin && v1[B_PCIN]) pcin_seen++;
  end

  logic [31:0] exp_pcs [10] = '{32'h1, 32'h2, 32'hF1, 32'hF2, 32'h2,
                                32'h3, 32'h8, 32'h9, 32'hA, 32'hB};
  logic [5:0] ram_s, pcin_s, mdrin_s;

  initial begin
    int t;
    for (int i = 0; i < 256; i++) mem[i] = {OP_NOP, 27'd0};
    mem[0]     = {OP_LDI, 4'd6, 4'd0, 19'hF1};   // ldi R6,0xF1
    mem[1]     = {OP_JAL, 4'd6, 4'd15, 19'd0};   // jal R6, link R15
    mem[8'hF1] = {OP_JR, 4'd15, 4'd0, 19'd0};    // jr R15
    mem[2]     = {OP_BR, 4'd6, 4'd0, 19'd5};     // br R6 (nonzero) -> taken
    mem[8]     = {OP_BR, 4'd0, 4'd0, 19'd5};     // br R0 (zero) -> not taken
    mem[9]     = {5'h1F, 27'd0};                 // illegal
    mem[10]    = {OP_HALT, 27'd0};
    pc_init = '0;
    clear = 1'b1; run = 1'b1;
    clear2 = 1'b1; run2 = 1'b0; con2 = 1'b0; ir2 = {OP_NOP, 27'd0};

    repeat (2) @(posedge clock);
    #1;
    check("reset", {v1, illegal, halted, instr_count, state},
          {20'd0, 1'b0, 1'b0, 16'd0, 4'd0});
    clear = 1'b0;

    // ldi, jal, jr: 16 cycles
    repeat (16) @(posedge clock);
    #1;
    check("count_after_16", instr_count, 3);
    check("pc_after_jr", dp_pc, 32'h2);
    check("r6", regs[6], 32'hF1);
    check("r15", regs[15], 32'h2);

    t = 0;
    while (!halted && t < 100) begin @(posedge clock); #1; t++; end
    check("halt_reached", halted, 1);
    repeat (20) @(posedge clock);
    #1;
    check("halt_hold", {halted, instr_count, v1}, {1'b1, 16'd7, 20'd0});
    check("illegal_pulses", ill_seen, 1);
    check("pc_trace_len", pcq.size(), 10);
    for (int i = 0; i < 10; i++)
      check("pc_trace", (i < pcq.size()) ? pcq[i] : 32'hFFFF_FFFF, exp_pcs[i]);

    // Abandon a jal before its T4
    pc_init = 32'h1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("jal_t3", v1, (20'd1 << B_PCOUT) | (20'd1 << B_GRB) | (20'd1 << B_RIN));
    watch_pcin = 1'b1;
    clear = 1'b1;
    @(posedge clock); #1;
    check("clear_mid", {v1, instr_count, state}, {20'd0, 16'd0, 4'd0});
    clear = 1'b0; run = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("no_pcin_after_clear", pcin_seen, 0);
    check("idle_after_clear", {instr_count, state}, {16'd0, 4'd0});

    // MEM_WAIT=2 nop
    @(posedge clock); #1;
    clear2 = 1'b0; run2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (k == 0) run2 = 1'b0;
      ram_s[k]   = v2[B_RAMRD];
      pcin_s[k]  = v2[B_PCIN];
      mdrin_s[k] = v2[B_MDRIN];
    end
    check("w2_ramread", ram_s, 6'b001110);
    check("w2_pcin", pcin_s, 6'b000010);
    check("w2_mdrin", mdrin_s, 6'b001000);
    check("w2_count_t3", count2, 0);
    @(posedge clock); #1;
    check("w2_done", {count2, state2, illegal2, halted2}, {16'd1, 4'd0, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench timed out at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
